zero_run_transmitter: RTL and testbench

//   Serial pattern source for the Mealy zero detector: on request, emits a run of N ones
//   on a single-bit line, then one terminating zero, then an idle gap of zeros.

---
 rtl/zero_run_transmitter_pkg.sv | 16 +
 rtl/zero_run_transmitter_if.sv | 28 ++
 rtl/zero_run_transmitter_run_down_counter.sv | 25 ++
 rtl/zero_run_transmitter.sv | 107 ++++++++++
 tb/tb_zero_run_transmitter.sv | 189 ++++++++++++++++++
 5 files changed

// File: rtl/zero_run_transmitter_pkg.sv
// Shared constants for the zero-run transmitter: state encoding and default sizes.
// The downstream zero detector and its benches use the same encoding.
package zero_run_transmitter_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_ONES = 2'd1;
  localparam state_t ST_ZERO = 2'd2;
  localparam state_t ST_GAP  = 2'd3;

  localparam int CNT_W_DEF  = 4;
  localparam int GAP_DEF    = 2;
  localparam int FCNT_W_DEF = 8;

endpackage

// File: rtl/zero_run_transmitter_if.sv
// Request/serial-output bundle of the zero-run transmitter.
// Handshake: a frame is accepted on a rising clock edge where start=1 and ready=1;
// start seen while ready=0 is dropped, never queued. run_len is sampled only at that edge.
interface zero_run_transmitter_if
  import zero_run_transmitter_pkg::*;
#(
    parameter int CNT_W  = CNT_W_DEF,
    parameter int FCNT_W = FCNT_W_DEF
);
    logic              start;
    logic [CNT_W-1:0]  run_len;
    logic              ready;
    logic              busy;
    logic              x_out;
    logic              done;
    logic [FCNT_W-1:0] frame_cnt;
    state_t            state;

    modport master (
        output start, run_len,
        input  ready, busy, x_out, done, frame_cnt, state
    );

    modport slave (
        input  start, run_len,
        output ready, busy, x_out, done, frame_cnt, state
    );
endinterface

// File: rtl/zero_run_transmitter_run_down_counter.sv
// Loadable down-counter with a zero flag; used for both the run length and the gap.
module zero_run_transmitter_run_down_counter #(
    parameter int W = 4
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         dec_i,
    output logic         zero_o
);
    logic [W-1:0] cnt_q;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else if (load_i) begin
            cnt_q <= load_val_i;
        end else if (dec_i) begin
            cnt_q <= cnt_q - W'(1);
        end
    end

    assign zero_o = (cnt_q == '0);
endmodule

// File: rtl/zero_run_transmitter.sv
// Emits run_len ones, one terminating zero (flagged by done), then GAP idle zeros.
// All outputs are registered so the serial line never glitches.
module zero_run_transmitter
  import zero_run_transmitter_pkg::*;
#(
    parameter int CNT_W  = CNT_W_DEF,
    parameter int GAP    = GAP_DEF,
    parameter int FCNT_W = FCNT_W_DEF
) (
    input  logic                    clock,
    input  logic                    reset,
    zero_run_transmitter_if.slave   bus
);
    localparam int GAP_W = (GAP > 1) ? $clog2(GAP) : 1;
    localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'((GAP > 0) ? GAP - 1 : 0);

    state_t            state_q, state_d;
    logic              x_out_q, done_q;
    logic [FCNT_W-1:0] frame_cnt_q;
    logic              run_load, run_dec, run_zero;
    logic              gap_load, gap_dec, gap_zero;

    zero_run_transmitter_run_down_counter #(.W(CNT_W)) u_run_cnt (
        .clock      (clock),
        .reset      (reset),
        .load_i     (run_load),
        .load_val_i (bus.run_len - CNT_W'(1)),
        .dec_i      (run_dec),
        .zero_o     (run_zero)
    );

    zero_run_transmitter_run_down_counter #(.W(GAP_W)) u_gap_cnt (
        .clock      (clock),
        .reset      (reset),
        .load_i     (gap_load),
        .load_val_i (GAP_LOAD),
        .dec_i      (gap_dec),
        .zero_o     (gap_zero)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        run_load = 1'b0;
        run_dec  = 1'b0;
        gap_load = 1'b0;
        gap_dec  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    // A zero-length request is a bare terminator frame.
                    if (bus.run_len != '0) begin
                        state_d  = ST_ONES;
                        run_load = 1'b1;
                    end else begin
                        state_d = ST_ZERO;
                    end
                end
            end
            ST_ONES: begin
                if (run_zero) state_d = ST_ZERO;
                else          run_dec = 1'b1;
            end
            ST_ZERO: begin
                if (GAP == 0) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d  = ST_GAP;
                    gap_load = 1'b1;
                end
            end
            default: begin
                if (gap_zero) state_d = ST_IDLE;
                else          gap_dec = 1'b1;
            end
        endcase
    end

    // Outputs are registered from the next state so they line up with state_q.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            x_out_q     <= 1'b0;
            done_q      <= 1'b0;
            frame_cnt_q <= '0;
        end else begin
            x_out_q <= (state_d == ST_ONES);
            done_q  <= (state_d == ST_ZERO);
            if (state_q == ST_ZERO) begin
                frame_cnt_q <= frame_cnt_q + FCNT_W'(1);
            end
        end
    end

    assign bus.ready     = (state_q == ST_IDLE);
    assign bus.busy      = (state_q != ST_IDLE);
    assign bus.x_out     = x_out_q;
    assign bus.done      = done_q;
    assign bus.frame_cnt = frame_cnt_q;
    assign bus.state     = state_q;
endmodule

// File: tb/tb_zero_run_transmitter.sv
// Directed bench for zero_run_transmitter (CNT_W=4, GAP=2, FCNT_W=8) with a
// behavioural Mealy zero-detector model on the serial line.
module tb_zero_run_transmitter;
  import zero_run_transmitter_pkg::*;

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  zero_run_transmitter_if #(.CNT_W(4), .FCNT_W(8)) bus ();

  zero_run_transmitter #(.CNT_W(4), .GAP(2), .FCNT_W(8)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  int total = 0;
  int bad   = 0;
  logic [0:0] exp_q[$];

  // Line monitor: detector pulses on a 1->0 transition; also counts done pulses
  // and any cycle where done and ready are both high.
  int   y_cnt = 0;
  int   done_cnt = 0;
  int   overlap_cnt = 0;
  logic x_prev = 1'b0;
  always @(negedge clock) begin
    if (!reset) begin
      x_prev = 1'b0;
    end else begin
      if (x_prev && !bus.x_out) y_cnt++;
      if (bus.done) done_cnt++;
      if (bus.done && bus.ready) overlap_cnt++;
      x_prev = bus.x_out;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  int y_base, d_base, ones, n;
  logic [0:0] e;

  initial begin
    bus.start   = 1'b0;
    bus.run_len = '0;

    // 1: reset state
    reset = 1'b0;
    tick(); tick();
    check("rst_x", bus.x_out, 0);
    check("rst_ready", bus.ready, 1);
    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.done, 0);
    check("rst_fcnt", bus.frame_cnt, 0);
    reset = 1'b1;
    tick();

    // 2: run_len=3 -> 1,1,1,0,0,0, done on the 4th cycle
    y_base = y_cnt;
    foreach (exp_q[i]) ;
    exp_q = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    bus.start = 1'b1; bus.run_len = 4'd3;
    tick();
    bus.start = 1'b0; bus.run_len = 4'd9;
    for (int i = 0; i < 6; i++) begin
      e = exp_q.pop_front();
      check($sformatf("f3_x%0d", i), bus.x_out, e);
      check($sformatf("f3_done%0d", i), bus.done, (i == 3) ? 1 : 0);
      check($sformatf("f3_ready%0d", i), bus.ready, 0);
      tick();
    end
    check("f3_ready_back", bus.ready, 1);
    check("f3_fcnt", bus.frame_cnt, 1);
    check("f3_ypulse", y_cnt - y_base, 1);

    // 3: run_len=0 -> bare terminator
    y_base = y_cnt;
    bus.start = 1'b1; bus.run_len = 4'd0;
    tick();
    bus.start = 1'b0;
    check("f0_x", bus.x_out, 0);
    check("f0_done", bus.done, 1);
    check("f0_ready", bus.ready, 0);
    tick();
    check("f0_done_off", bus.done, 0);
    check("f0_fcnt", bus.frame_cnt, 2);
    tick(); tick();
    check("f0_ready_back", bus.ready, 1);
    check("f0_ypulse", y_cnt - y_base, 0);

    // 4: start held, run_len=1 -> 1,0,0,0,0 repeating
    bus.start = 1'b1; bus.run_len = 4'd1;
    tick();
    for (int f = 0; f < 3; f++) begin
      exp_q.push_back(1'b1);
      for (int j = 0; j < 4; j++) exp_q.push_back(1'b0);
    end
    for (int i = 0; i < 15; i++) begin
      e = exp_q.pop_front();
      check($sformatf("b2b_x%0d", i), bus.x_out, e);
      check($sformatf("b2b_done%0d", i), bus.done, (i % 5 == 1) ? 1 : 0);
      check($sformatf("b2b_ready%0d", i), bus.ready, (i % 5 == 4) ? 1 : 0);
      if (i == 14) bus.start = 1'b0;
      tick();
    end
    check("b2b_idle", bus.ready, 1);
    check("b2b_fcnt", bus.frame_cnt, 5);

    // 5: reset on the 5th ONES cycle of a 15-long run
    reset = 1'b0; tick(); reset = 1'b1; tick();
    check("ab_fcnt_pre", bus.frame_cnt, 0);
    d_base = done_cnt;
    y_base = y_cnt;
    bus.start = 1'b1; bus.run_len = 4'd15;
    tick();
    bus.start = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    check("ab_x_before", bus.x_out, 1);
    reset = 1'b0;
    #1;
    check("ab_x_now", bus.x_out, 0);
    check("ab_done_now", bus.done, 0);
    tick(); tick();
    reset = 1'b1;
    tick();
    check("ab_ready", bus.ready, 1);
    check("ab_x_after", bus.x_out, 0);
    for (int i = 0; i < 15; i++) tick();
    check("ab_done_never", done_cnt - d_base, 0);
    check("ab_fcnt", bus.frame_cnt, 0);
    check("ab_ypulse", y_cnt - y_base, 0);

    // 6: start pulsed while busy is ignored
    bus.start = 1'b1; bus.run_len = 4'd2;
    tick();
    bus.start = 1'b0;
    tick();
    check("ig_busy", bus.busy, 1);
    bus.start = 1'b1; bus.run_len = 4'd7;
    tick();
    bus.start = 1'b0;
    n = 0;
    while (!bus.ready && n < 20) begin
      tick();
      n++;
    end
    check("ig_len", n + 2, 5);
    check("ig_fcnt", bus.frame_cnt, 1);
    ones = 0;
    for (int i = 0; i < 12; i++) begin
      if (bus.x_out) ones++;
      tick();
    end
    check("ig_no_extra", ones, 0);
    check("ig_fcnt_hold", bus.frame_cnt, 1);

    // 7: frame_cnt wraps 255 -> 0 with bare frames held back to back
    d_base = done_cnt;
    bus.start = 1'b1; bus.run_len = 4'd0;
    tick();
    n = 0;
    while (bus.frame_cnt != 8'd0 && n < 2000) begin
      tick();
      n++;
    end
    bus.start = 1'b0;
    check("wrap_fcnt", bus.frame_cnt, 0);
    check("wrap_frames", done_cnt - d_base, 255);

    tick(); tick(); tick(); tick(); tick();
    check("no_done_ready_overlap", overlap_cnt, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
